nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Frequency-sweep sequencer for the `nco` block. It accepts a sweep descriptor over a valid/ready handshake and optionally waits for an external trigger. It then drives the NCO tuning word and enable through a stepped linear sweep, holding each frequency for a programmed dwell. It sits between the control/register side and `nco`, owning `Q_freq` and `en`.

## Interface
Parameters:
- `FW`, 32: tuning-word width; matches `nco` `Q_freq`.
- `CW`, 16: width of the step-count and dwell fields.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, shared with `nco`.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  descriptor valid.
- `cfg_ready`  out  1  descriptor accepted when `cfg_valid && cfg_ready` at a rising edge.
- `cfg_start`  in  FW  first tuning word.
- `cfg_step`  in  FW  signed two's-complement increment per step.
- `cfg_count`  in  CW  number of frequencies in the sweep; 0 is treated as 1.
- `cfg_dwell`  in  CW  cycles held per frequency; 0 is treated as 1.
- `cfg_repeat`  in  1  1: restart from `cfg_start` after the last frequency; 0: one-shot.
- `cfg_trig`  in  1  1: wait in ARM for `trig`; 0: start immediately.
- `trig`  in  1  start trigger, level-sampled in ARM.
- `abort`  in  1  stop the sweep and return to IDLE.
- `freq`  out  FW  tuning word to `nco` `Q_freq`.
- `nco_en`  out  1  enable to `nco`.
- `step_strobe`  out  1  one-cycle pulse in the first cycle of each new frequency after the first.
- `wrap_strobe`  out  1  one-cycle pulse when a repeat sweep reloads `cfg_start`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a one-shot sweep.

## Operation
- States: IDLE, ARM, DWELL, DONE.
- IDLE
  - `cfg_ready = !abort`.
  - On accept, latch all `cfg_*` fields.
  - Go to ARM if `cfg_trig`, otherwise go to DWELL.
- ARM
  - `nco_en = 0`; `freq` already equals `cfg_start`.
  - `trig = 1` → DWELL.
- DWELL
  - `nco_en = 1`.
  - Dwell counter is loaded with D−1 on entry and on each step, where D = max(`cfg_dwell`,1).
  - When the dwell counter reaches 0 and the frequency index < N−1 (N = max(`cfg_count`,1)): `freq <= freq + step`, increment the index, reload the dwell counter, pulse `step_strobe`.
  - When the dwell counter reaches 0 and the index = N−1:
    - repeat mode: `freq <= start`, index 0, pulse `wrap_strobe` (no `step_strobe`).
    - one-shot mode: go to DONE.
- DONE
  - Lasts one cycle: `done = 1`, `nco_en = 0`, `freq` holds the last value.
  - Then go to IDLE.
- Arithmetic: `freq + step` is computed modulo 2^FW by default (see Configuration).
- Abort
  - In ARM, DWELL or DONE: next state is IDLE, `nco_en = 0` next cycle, no `done` pulse, `freq` holds.
  - In IDLE: `abort` blocks acceptance.
- Simultaneous events
  - `abort` and `trig` in ARM: abort wins.
  - `abort` in the last dwell cycle: abort wins; no step, wrap or done.
  - `cfg_valid` outside IDLE: ignored, because `cfg_ready = 0`.

## Timing
- Reset values: state IDLE, `freq = 0`, `nco_en = 0`, `cfg_ready = 1`, `busy = 0`, all strobes 0, counters 0.
- All outputs are registered; none is combinational from inputs except `cfg_ready` (`IDLE && !abort`).
- Accept at edge T (no trigger):
  - In cycle T+1: `freq = start`, `nco_en = 1`, `busy = 1`.
  - Each frequency is presented for exactly D cycles.
- Accept at edge T with trigger: first DWELL cycle is the cycle after the edge at which `trig` is sampled high.
- One-shot end:
  - Last frequency occupies cycles T+1+(N−1)D … T+ND.
  - DONE is cycle T+ND+1.
  - IDLE (`cfg_ready = 1`) at T+ND+2.
- Repeat mode: there is no gap cycle between the last frequency and the reloaded start.

## Configuration
- `NCO_SWEEP_SAT_EN` defined:
  - `freq + step` saturates at 0 (negative step) and 2^FW−1 (positive step).
  - Once saturated, later steps hold the value; `step_strobe` still pulses.
- `NCO_SWEEP_SAT_EN` undefined: modulo-2^FW wrap-around, no clamp.

## Structure
- Shared package `nco_sweep_pkg`:
  - state enum (IDLE, ARM, DWELL, DONE);
  - default `FW` and `CW` constants.
- Sub-module `nco_sweep_addsat`: combinational FW-bit `freq` + signed `step`, with the saturation logic under `NCO_SWEEP_SAT_EN`.
- Counters and FSM live in `nco_sweep_ctrl`.

## Test plan
- Basic one-shot, no trigger. Config: start=100, step=10, count=3, dwell=2.
  - Required: `freq` = 100,100,110,110,120,120 over cycles T+1..T+6.
  - `step_strobe` at T+3 and T+5; `done` at T+7; `nco_en` 0 at T+7.
- Trigger wait. Config: start=5, step=1, count=2, dwell=1, cfg_trig=1; `trig` held low for 4 cycles.
  - Required: `nco_en` stays 0 while `trig` is low.
  - Required: `freq` = 5 then 6 starting the cycle after `trig` goes high.
- Repeat mode. Config: start=0, step=7, count=2, dwell=1, repeat=1.
  - Required: `freq` = 0,7,0,7,…
  - `wrap_strobe` at each reload to 0; `done` never pulses.
- Zero fields. Config: count=0, dwell=0, start=42.
  - Required: one cycle at 42, `done` in the next cycle.
- Wrap or saturation. Config: start=0xFFFFFFF0, step=0x20, count=2, dwell=1.
  - Required: second frequency 0x00000010 without `NCO_SWEEP_SAT_EN`; 0xFFFFFFFF with it.
- Abort and reset. Case 1: assert `abort` mid-dwell.
  - Required: IDLE next cycle, `nco_en` 0, no `done`, `freq` held.
  - Case 2: assert `rst` mid-sweep. Required: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/nco_sweep_pkg.sv
// Shared types and defaults for the NCO frequency-sweep sequencer.
package nco_sweep_pkg;

  localparam int unsigned FwDefault = 32;
  localparam int unsigned CwDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StDwell,
    StDone
  } state_e;

endpackage

// File: rtl/nco_sweep_addsat.sv
// Tuning-word adder: unsigned freq plus two's-complement step.
// Saturates at 0 / all-ones when NCO_SWEEP_SAT_EN is defined, wraps otherwise.
module nco_sweep_addsat
  import nco_sweep_pkg::*;
#(
  parameter int unsigned FW = FwDefault
) (
  input  logic [FW-1:0] freq_i,
  input  logic [FW-1:0] step_i,
  output logic [FW-1:0] sum_o
);

`ifdef NCO_SWEEP_SAT_EN
  logic [FW:0] raw;

  assign raw = {1'b0, freq_i} + {1'b0, step_i};

  // Carry-out set on a positive step means overflow; clear on a negative step means underflow.
  always_comb begin
    sum_o = raw[FW-1:0];
    if (!step_i[FW-1] && raw[FW]) begin
      sum_o = '1;
    end else if (step_i[FW-1] && !raw[FW]) begin
      sum_o = '0;
    end
  end
`else
  assign sum_o = freq_i + step_i;
`endif

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency-sweep sequencer driving the NCO tuning word and enable.
// Optional saturating step arithmetic via NCO_SWEEP_SAT_EN (see nco_sweep_addsat).
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int unsigned FW = FwDefault,
  parameter int unsigned CW = CwDefault
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_start,
  input  logic [FW-1:0] cfg_step,
  input  logic [CW-1:0] cfg_count,
  input  logic [CW-1:0] cfg_dwell,
  input  logic          cfg_repeat,
  input  logic          cfg_trig,
  input  logic          trig,
  input  logic          abort,
  output logic [FW-1:0] freq,
  output logic          nco_en,
  output logic          step_strobe,
  output logic          wrap_strobe,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] start_q, start_d;
  logic [FW-1:0] inc_q, inc_d;
  logic [CW-1:0] last_idx_q, last_idx_d;
  logic [CW-1:0] dwell_ld_q, dwell_ld_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic          repeat_q, repeat_d;
  logic          nco_en_q, nco_en_d;
  logic          step_strobe_q, step_strobe_d;
  logic          wrap_strobe_q, wrap_strobe_d;
  logic          done_q, done_d;
  logic [FW-1:0] step_sum;

  // Zero-length fields behave as length one, so the terminal value is max(v,1)-1.
  function automatic logic [CW-1:0] floor_m1(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  nco_sweep_addsat #(
    .FW(FW)
  ) u_addsat (
    .freq_i(freq_q),
    .step_i(inc_q),
    .sum_o (step_sum)
  );

  assign cfg_ready   = (state_q == StIdle) && !abort;
  assign busy        = (state_q != StIdle);
  assign freq        = freq_q;
  assign nco_en      = nco_en_q;
  assign step_strobe = step_strobe_q;
  assign wrap_strobe = wrap_strobe_q;
  assign done        = done_q;

  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    start_d       = start_q;
    inc_d         = inc_q;
    last_idx_d    = last_idx_q;
    dwell_ld_d    = dwell_ld_q;
    idx_d         = idx_q;
    dwell_cnt_d   = dwell_cnt_q;
    repeat_d      = repeat_q;
    nco_en_d      = nco_en_q;
    step_strobe_d = 1'b0;
    wrap_strobe_d = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        nco_en_d = 1'b0;
        if (cfg_valid && cfg_ready) begin
          start_d     = cfg_start;
          inc_d       = cfg_step;
          last_idx_d  = floor_m1(cfg_count);
          dwell_ld_d  = floor_m1(cfg_dwell);
          repeat_d    = cfg_repeat;
          freq_d      = cfg_start;
          idx_d       = '0;
          dwell_cnt_d = floor_m1(cfg_dwell);
          state_d     = cfg_trig ? StArm : StDwell;
          nco_en_d    = !cfg_trig;
        end
      end
      StArm: begin
        if (abort) begin
          state_d  = StIdle;
          nco_en_d = 1'b0;
        end else if (trig) begin
          state_d     = StDwell;
          nco_en_d    = 1'b1;
          dwell_cnt_d = dwell_ld_q;
        end
      end
      StDwell: begin
        if (abort) begin
          state_d  = StIdle;
          nco_en_d = 1'b0;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - CW'(1);
        end else if (idx_q != last_idx_q) begin
          freq_d        = step_sum;
          idx_d         = idx_q + CW'(1);
          dwell_cnt_d   = dwell_ld_q;
          step_strobe_d = 1'b1;
        end else if (repeat_q) begin
          freq_d        = start_q;
          idx_d         = '0;
          dwell_cnt_d   = dwell_ld_q;
          wrap_strobe_d = 1'b1;
        end else begin
          state_d  = StDone;
          nco_en_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      StDone: begin
        state_d  = StIdle;
        nco_en_d = 1'b0;
      end
      default: begin
        state_d  = StIdle;
        nco_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      freq_q        <= '0;
      start_q       <= '0;
      inc_q         <= '0;
      last_idx_q    <= '0;
      dwell_ld_q    <= '0;
      idx_q         <= '0;
      dwell_cnt_q   <= '0;
      repeat_q      <= 1'b0;
      nco_en_q      <= 1'b0;
      step_strobe_q <= 1'b0;
      wrap_strobe_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      start_q       <= start_d;
      inc_q         <= inc_d;
      last_idx_q    <= last_idx_d;
      dwell_ld_q    <= dwell_ld_d;
      idx_q         <= idx_d;
      dwell_cnt_q   <= dwell_cnt_d;
      repeat_q      <= repeat_d;
      nco_en_q      <= nco_en_d;
      step_strobe_q <= step_strobe_d;
      wrap_strobe_q <= wrap_strobe_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized bench for nco_sweep_ctrl: per-transaction expected output trace
// built from the sweep rules, compared every cycle on the falling edge.
module tb_nco_sweep_ctrl;

  localparam int unsigned FW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [FW-1:0] cfg_start = '0;
  logic [FW-1:0] cfg_step = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [CW-1:0] cfg_dwell = '0;
  logic          cfg_repeat = 1'b0;
  logic          cfg_trig = 1'b0;
  logic          trig = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] freq;
  logic          nco_en;
  logic          step_strobe;
  logic          wrap_strobe;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(
    .FW(FW),
    .CW(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_step   (cfg_step),
    .cfg_count  (cfg_count),
    .cfg_dwell  (cfg_dwell),
    .cfg_repeat (cfg_repeat),
    .cfg_trig   (cfg_trig),
    .trig       (trig),
    .abort      (abort),
    .freq       (freq),
    .nco_en     (nco_en),
    .step_strobe(step_strobe),
    .wrap_strobe(wrap_strobe),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [31:0] f;
    bit          en;
    bit          stp;
    bit          wrp;
    bit          dn;
    bit          bz;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        gen_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_freq = '0;
  bit          run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_add(input logic [31:0] f, input logic [31:0] s);
`ifdef NCO_SWEEP_SAT_EN
    longint r;
    r = longint'(f) + longint'($signed(s));
    if (r < 0) r = 0;
    if (r > 64'sh0_FFFF_FFFF) r = 64'sh0_FFFF_FFFF;
    return r[31:0];
`else
    return f + s;
`endif
  endfunction

  // Full expected trace from the cycle after acceptance: ARM wait, passes of
  // N frequencies held D cycles each, then the DONE cycle for one-shot sweeps.
  task automatic build(input logic [31:0] st, input logic [31:0] sp, input int cnt, input int dw,
                       input bit rep, input bit trg, input int w, input int passes);
    int          n;
    int          d;
    logic [31:0] f;
    n = (cnt == 0) ? 1 : cnt;
    d = (dw == 0) ? 1 : dw;
    f = st;
    gen_q.delete();
    if (trg) for (int i = 0; i <= w; i++) gen_q.push_back('{st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int p = 0; p < passes; p++) begin
      f = st;
      for (int k = 0; k < n; k++) begin
        if (k > 0) f = model_add(f, sp);
        for (int j = 0; j < d; j++)
          gen_q.push_back('{f, 1'b1, (k > 0 && j == 0), (p > 0 && k == 0 && j == 0), 1'b0, 1'b1});
      end
    end
    if (!rep) gen_q.push_back('{f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (run && !rst) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{last_freq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      chk("freq", freq, e.f);
      chk("nco_en", 32'(nco_en), 32'(e.en));
      chk("step_strobe", 32'(step_strobe), 32'(e.stp));
      chk("wrap_strobe", 32'(wrap_strobe), 32'(e.wrp));
      chk("done", 32'(done), 32'(e.dn));
      chk("busy", 32'(busy), 32'(e.bz));
      chk("cfg_ready", 32'(cfg_ready), e.bz ? 32'd0 : 32'(!abort));
      last_freq = e.f;
    end
  end

  // Called #1 after a rising edge in an IDLE cycle. abort_at: -1 none, -2 random,
  // otherwise the trace index of the cycle during which abort is held.
  task automatic run_txn(input logic [31:0] st, input logic [31:0] sp, input int cnt, input int dw,
                         input bit rep, input bit trg, input int w, input int passes,
                         input int abort_at, input bit hold_valid);
    int len;
    int ab;
    cfg_start  = st;
    cfg_step   = sp;
    cfg_count  = CW'(cnt);
    cfg_dwell  = CW'(dw);
    cfg_repeat = rep;
    cfg_trig   = trg;
    cfg_valid  = 1'b1;
    trig       = 1'b0;
    @(posedge clk);
    #1;
    build(st, sp, cnt, dw, rep, trg, w, passes);
    ab = abort_at;
    if (ab == -2) ab = $urandom_range(0, gen_q.size() - 1);
    len = (ab >= 0 && ab < gen_q.size()) ? ab + 1 : gen_q.size();
    for (int i = 0; i < len; i++) exp_q.push_back(gen_q[i]);
    if (hold_valid) begin
      cfg_start = $urandom;
      cfg_count = CW'($urandom_range(0, 3));
    end
    for (int c = 0; c < len; c++) begin
      cfg_valid = hold_valid && (c == 0);
      trig      = trg && (c >= w);
      abort     = (c == ab);
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    trig      = 1'b0;
    abort     = 1'b0;
    chk("trace_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] basic_lit[6] = '{32'd100, 32'd100, 32'd110, 32'd110, 32'd120, 32'd120};

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_freq", freq, 32'd0);
    chk("rst_nco_en", 32'(nco_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_strobes", {29'd0, step_strobe, wrap_strobe, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;

    // Basic one-shot.
    run_txn(32'd100, 32'd10, 3, 2, 1'b0, 1'b0, 0, 1, -1, 1'b0);
    for (int i = 0; i < 6; i++) chk("pin_basic_freq", gen_q[i].f, basic_lit[i]);
    chk("pin_basic_step", {30'd0, gen_q[2].stp, gen_q[4].stp}, 32'd3);
    chk("pin_basic_done", {30'd0, gen_q[6].dn, gen_q[6].en}, 32'd2);

    // Trigger wait.
    run_txn(32'd5, 32'd1, 2, 1, 1'b0, 1'b1, 4, 1, -1, 1'b0);
    chk("pin_trig_arm", {gen_q[4].f[30:0], gen_q[4].en}, {31'd5, 1'b0});
    chk("pin_trig_seq", {gen_q[5].f[15:0], gen_q[6].f[15:0]}, {16'd5, 16'd6});

    // Repeat mode, aborted after three passes.
    run_txn(32'd0, 32'd7, 2, 1, 1'b1, 1'b0, 0, 3, 5, 1'b0);
    chk("pin_rep_seq", {gen_q[2].f[7:0], gen_q[3].f[7:0]}, {8'd0, 8'd7});
    chk("pin_rep_wrap", {30'd0, gen_q[2].wrp, gen_q[2].stp}, 32'd2);

    // Zero fields.
    run_txn(32'd42, 32'd9, 0, 0, 1'b0, 1'b0, 0, 1, -1, 1'b0);
    chk("pin_zero", {gen_q[0].f[30:0], gen_q[1].dn}, {31'd42, 1'b1});

    // Wrap-around or saturation.
    run_txn(32'hFFFF_FFF0, 32'h20, 2, 1, 1'b0, 1'b0, 0, 1, -1, 1'b0);
`ifdef NCO_SWEEP_SAT_EN
    chk("pin_wrap", gen_q[1].f, 32'hFFFF_FFFF);
`else
    chk("pin_wrap", gen_q[1].f, 32'h0000_0010);
`endif

    // Abort mid-dwell, with cfg_valid held into the busy phase.
    run_txn(32'd1000, 32'd3, 4, 3, 1'b0, 1'b0, 0, 1, 4, 1'b1);
    chk("pin_abort_hold", gen_q[4].f, 32'd1003);

    // Abort in IDLE blocks acceptance.
    cfg_valid = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 40; t++) begin
      logic [31:0] sp;
      bit          rep;
      sp  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
      rep = ($urandom_range(0, 3) == 0);
      run_txn($urandom, sp, $urandom_range(0, 5), $urandom_range(0, 3), rep,
              ($urandom_range(0, 9) < 3), $urandom_range(0, 3),
              rep ? $urandom_range(2, 3) : 1,
              (rep || $urandom_range(0, 9) < 3) ? -2 : -1, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset mid-sweep.
    run_txn(32'd77, 32'd1, 10, 3, 1'b0, 1'b0, 0, 1, 3, 1'b0);
    cfg_start = 32'd500;
    cfg_count = CW'(10);
    cfg_dwell = CW'(3);
    cfg_trig  = 1'b0;
    cfg_repeat = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    build(32'd500, 32'd1, 10, 3, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < gen_q.size(); i++) exp_q.push_back(gen_q[i]);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_freq", freq, 32'd0);
    chk("mid_rst_nco_en", 32'(nco_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("mid_rst_strobes", {29'd0, step_strobe, wrap_strobe, done}, 32'd0);
    exp_q.delete();
    last_freq = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
